// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
//   arb_state_t   : arbiter FSM state encoding (IDLE, LOAD, SEND, HOLD)
//   GRANT_*       : one-hot owner constants driven on the grant output
//   STOP_BIT_IDX  : index of the stop bit inside a 10-bit 8N1 frame
//   grant_of()    : maps a requester index to its one-hot grant value
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  // Frame bit slots: 0 = start, 1..8 = data LSB first, 9 = stop.
  localparam logic [3:0] LAST_DATA_IDX = 4'd8;
  localparam logic [3:0] STOP_BIT_IDX  = 4'd9;

  function automatic logic [1:0] grant_of(input logic owner);
    return owner ? GRANT_1 : GRANT_0;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_tx.sv
// uart_tx: 8N1 serializer, LSB first, line idles high.
//   clk_in  : clock, all state on the rising edge
//   reset   : synchronous active-high reset, returns the line to idle
//   start   : one-cycle request; data is captured on the same edge and the
//             start bit appears on tx_out the following cycle
//   data    : byte to send, sampled only when start is high
//   tx_out  : registered serial line
//   done    : high during the final cycle of the stop bit
module uart_tx
  import uart_tx_arbiter_pkg::*;
#(
  parameter int                               UART_TICKS_PER_BIT_SIZE = 7,
  parameter logic [UART_TICKS_PER_BIT_SIZE-1:0] UART_TICKS_PER_BIT    = 7'd65
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx_out,
  output logic       done
);

  localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] TICK_LAST = UART_TICKS_PER_BIT - 1'b1;

  logic                               busy_reg;
  logic [3:0]                         bit_idx_reg;
  logic [UART_TICKS_PER_BIT_SIZE-1:0] tick_reg;
  logic [7:0]                         shift_reg;
  logic                               tx_reg;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      busy_reg    <= 1'b0;
      bit_idx_reg <= '0;
      tick_reg    <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else if (start) begin
      // Start bit goes out on the very next cycle so the arbiter handshake
      // and the falling edge of the frame are only one cycle apart.
      busy_reg    <= 1'b1;
      bit_idx_reg <= '0;
      tick_reg    <= '0;
      shift_reg   <= data;
      tx_reg      <= 1'b0;
    end else if (busy_reg) begin
      if (tick_reg == TICK_LAST) begin
        tick_reg <= '0;
        if (bit_idx_reg == STOP_BIT_IDX) begin
          busy_reg <= 1'b0;
          tx_reg   <= 1'b1;
        end else begin
          bit_idx_reg <= bit_idx_reg + 4'd1;
          if (bit_idx_reg == LAST_DATA_IDX) begin
            tx_reg <= 1'b1;
          end else begin
            tx_reg    <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end
        end
      end else begin
        tick_reg <= tick_reg + 1'b1;
      end
    end
  end

  assign tx_out = tx_reg;
  assign done   = busy_reg && (bit_idx_reg == STOP_BIT_IDX) && (tick_reg == TICK_LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte requesters.
// An owner keeps the line for a whole message (until a byte flagged last
// has been sent) unless it stays silent for LOCK_TIMEOUT_TICKS cycles.
// Simultaneous requests from IDLE are resolved round-robin.
//   clk_in, reset            : clock and synchronous active-high reset
//   reqN_valid/data/last     : requester N byte stream (N = 0, 1)
//   reqN_ready               : one-cycle accept strobe, owner only
//   tx_out                   : 8N1 serial line
//   grant                    : one-hot current owner, 2'b00 when none
//   busy                     : arbiter FSM is not in IDLE
//   bytes_sent               : completed bytes, wraps
//   timeouts                 : lock-timeout releases, saturates
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int                               UART_TICKS_PER_BIT_SIZE = 7,
  parameter logic [UART_TICKS_PER_BIT_SIZE-1:0] UART_TICKS_PER_BIT    = 7'd65,
  parameter logic [15:0]                      LOCK_TIMEOUT_TICKS      = 16'd2000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  input  logic       req0_last,
  input  logic       req1_last,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       tx_out,
  output logic [1:0] grant,
  output logic       busy,
  output logic [7:0] bytes_sent,
  output logic [7:0] timeouts
);

  localparam logic [15:0] HOLD_LAST = LOCK_TIMEOUT_TICKS - 16'd1;

  arb_state_t  state_reg;
  logic        owner_reg;
  logic        rr_ptr_reg;
  logic [1:0]  grant_reg;
  logic [1:0]  ready_reg;
  logic [15:0] hold_cnt_reg;
  logic [7:0]  bytes_reg;
  logic [7:0]  timeouts_reg;
  logic        last_reg;

  logic        owner_valid;
  logic [7:0]  owner_data;
  logic        owner_last;
  logic        idle_pick;
  logic        tx_start;
  logic        tx_done;

  // Only the owner's signals are ever looked at; the other side may do
  // anything while it waits.
  assign owner_valid = owner_reg ? req1_valid : req0_valid;
  assign owner_data  = owner_reg ? req1_data  : req0_data;
  assign owner_last  = owner_reg ? req1_last  : req0_last;

  // Lone requester wins outright; a tie goes to the round-robin pointer.
  assign idle_pick = (req0_valid && req1_valid) ? rr_ptr_reg : req1_valid;

  // The start strobe is the handshake itself, so the serializer captures
  // the byte on the same edge the requester sees it accepted.
  assign tx_start = (state_reg == ST_LOAD) && owner_valid;

  uart_tx #(
    .UART_TICKS_PER_BIT_SIZE(UART_TICKS_PER_BIT_SIZE),
    .UART_TICKS_PER_BIT     (UART_TICKS_PER_BIT)
  ) u_uart_tx (
    .clk_in (clk_in),
    .reset  (reset),
    .start  (tx_start),
    .data   (owner_data),
    .tx_out (tx_out),
    .done   (tx_done)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= 1'b0;
      rr_ptr_reg   <= 1'b0;
      grant_reg    <= GRANT_NONE;
      ready_reg    <= GRANT_NONE;
      hold_cnt_reg <= '0;
      bytes_reg    <= '0;
      timeouts_reg <= '0;
      last_reg     <= 1'b0;
    end else begin
      // ready is a single-cycle strobe raised only on entry to LOAD.
      ready_reg <= GRANT_NONE;
      case (state_reg)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            owner_reg <= idle_pick;
            grant_reg <= grant_of(idle_pick);
            ready_reg <= grant_of(idle_pick);
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (owner_valid) begin
            last_reg  <= owner_last;
            state_reg <= ST_SEND;
          end else begin
            hold_cnt_reg <= '0;
            state_reg    <= ST_HOLD;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            bytes_reg <= bytes_reg + 8'd1;
            if (last_reg) begin
              grant_reg  <= GRANT_NONE;
              rr_ptr_reg <= ~owner_reg;
              state_reg  <= ST_IDLE;
            end else begin
              hold_cnt_reg <= '0;
              state_reg    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (owner_valid) begin
            hold_cnt_reg <= '0;
            ready_reg    <= grant_of(owner_reg);
            state_reg    <= ST_LOAD;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            // Silent owner loses the line; the other side gets the next tie.
            hold_cnt_reg <= '0;
            grant_reg    <= GRANT_NONE;
            rr_ptr_reg   <= ~owner_reg;
            if (timeouts_reg != 8'hFF) begin
              timeouts_reg <= timeouts_reg + 8'd1;
            end
            state_reg    <= ST_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = ready_reg[0];
  assign req1_ready = ready_reg[1];
  assign grant      = grant_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign bytes_sent = bytes_reg;
  assign timeouts   = timeouts_reg;

endmodule
